// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares one 8-digit seven-seg display between keypad,
// CPU MMIO and a transient alert source, on the 1 ms tube clock.
// Ports:
//   clk_tube, rst_n (async, active-low)
//   kp_req/kp_value, cpu_req/cpu_value  level-sensitive requesters
//   alert_req/alert_value               rising-edge alert trigger + code
//   kp_gnt/cpu_gnt/alert_gnt/owner      registered one-hot grants, owner code
//   display_value/display_blank         value to driver, digit-enable gate
// Optional macro: ALERT_BLINK_EN (blank toggles every BLINK_TICKS in ALERT).
module seg_display_arbiter #(
   parameter int VALUE_W     = 27,
   parameter int HOLD_TICKS  = 500,
   parameter int ALERT_TICKS = 2000,
   parameter int BLINK_TICKS = 250
) (
   input  logic               clk_tube,
   input  logic               rst_n,
   input  logic               kp_req,
   input  logic [VALUE_W-1:0] kp_value,
   input  logic               cpu_req,
   input  logic [VALUE_W-1:0] cpu_value,
   input  logic               alert_req,
   input  logic [VALUE_W-1:0] alert_value,
   output logic               kp_gnt,
   output logic               cpu_gnt,
   output logic               alert_gnt,
   output logic [1:0]         owner,
   output logic [VALUE_W-1:0] display_value,
   output logic               display_blank
);

   localparam int HW = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
   localparam int AW = (ALERT_TICKS > 1) ? $clog2(ALERT_TICKS) : 1;

   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS - 1);
   localparam logic [AW-1:0] ALERT_LOAD = AW'(ALERT_TICKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_KP    = 2'd1,
      ST_CPU   = 2'd2,
      ST_ALERT = 2'd3
   } state_t;

   state_t             r_state;
   logic [HW-1:0]      r_hold_cnt;
   logic [AW-1:0]      r_alert_cnt;
   logic               r_alert_prev;
   logic [VALUE_W-1:0] r_value;
   logic               r_blank;

   state_t             w_state_nx;
   state_t             w_arb;
   logic [HW-1:0]      w_hold_nx;
   logic [AW-1:0]      w_alert_nx;
   logic [VALUE_W-1:0] w_value_nx;
   logic               w_blank_nx;
   logic               w_alert_edge;
   logic               w_rearb;

`ifdef ALERT_BLINK_EN
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_TICKS - 1);
   logic [BW-1:0] r_blink_cnt;
   logic [BW-1:0] w_blink_nx;
`else
   logic w_unused_blink;
   assign w_unused_blink = |BLINK_TICKS;
`endif

   always_ff @(posedge clk_tube or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_hold_cnt   <= '0;
         r_alert_cnt  <= '0;
         r_alert_prev <= 1'b0;
         r_value      <= '0;
         r_blank      <= 1'b1;
      end else begin
         r_state      <= w_state_nx;
         r_hold_cnt   <= w_hold_nx;
         r_alert_cnt  <= w_alert_nx;
         r_alert_prev <= alert_req;
         r_value      <= w_value_nx;
         r_blank      <= w_blank_nx;
      end
   end

`ifdef ALERT_BLINK_EN
   always_ff @(posedge clk_tube or negedge rst_n) begin
      if (!rst_n) r_blink_cnt <= '0;
      else        r_blink_cnt <= w_blink_nx;
   end
`endif

   always_comb begin
      w_alert_edge = alert_req & ~r_alert_prev;
      w_arb        = cpu_req ? ST_CPU : (kp_req ? ST_KP : ST_IDLE);
      w_state_nx   = r_state;
      w_hold_nx    = (r_hold_cnt != '0) ? r_hold_cnt - 1'b1 : r_hold_cnt;
      w_alert_nx   = r_alert_cnt;
      w_value_nx   = r_value;
      w_blank_nx   = r_blank;
      w_rearb      = 1'b0;
`ifdef ALERT_BLINK_EN
      w_blink_nx   = r_blink_cnt;
`endif

      if (w_alert_edge) begin
         // Entry and retrigger are the same load: fresh window, new code.
         w_state_nx = ST_ALERT;
         w_alert_nx = ALERT_LOAD;
         w_value_nx = alert_value;
         w_blank_nx = 1'b0;
`ifdef ALERT_BLINK_EN
         w_blink_nx = BLINK_LOAD;
`endif
      end else begin
         unique case (r_state)
            ST_IDLE: w_rearb = 1'b1;
            ST_KP: begin
               if (r_hold_cnt == '0 && (!kp_req || cpu_req))
                  w_rearb = 1'b1;
               else if (kp_req)
                  w_value_nx = kp_value;
            end
            ST_CPU: begin
               if (r_hold_cnt == '0 && !cpu_req)
                  w_rearb = 1'b1;
               else if (cpu_req)
                  w_value_nx = cpu_value;
            end
            ST_ALERT: begin
               if (r_alert_cnt == '0) begin
                  w_rearb = 1'b1;
               end else begin
                  w_alert_nx = r_alert_cnt - 1'b1;
`ifdef ALERT_BLINK_EN
                  if (r_blink_cnt == '0) begin
                     w_blank_nx = ~r_blank;
                     w_blink_nx = BLINK_LOAD;
                  end else begin
                     w_blink_nx = r_blink_cnt - 1'b1;
                  end
`endif
               end
            end
            default: w_rearb = 1'b1;
         endcase
      end

      // Re-arbitration goes straight to the winner; no IDLE bubble.
      if (w_rearb) begin
         w_state_nx = w_arb;
         w_hold_nx  = HOLD_LOAD;
         unique case (1'b1)
            (w_arb == ST_CPU): begin
               w_value_nx = cpu_value;
               w_blank_nx = 1'b0;
            end
            (w_arb == ST_KP): begin
               w_value_nx = kp_value;
               w_blank_nx = 1'b0;
            end
            default: w_blank_nx = 1'b1;
         endcase
      end
   end

   assign kp_gnt        = (r_state == ST_KP);
   assign cpu_gnt       = (r_state == ST_CPU);
   assign alert_gnt     = (r_state == ST_ALERT);
   assign owner         = r_state;
   assign display_value = r_value;
   assign display_blank = r_blank;

endmodule
